countdown_timer: RTL

Loadable down-counting timer: the count-down counterpart to the team's up counter. Counts a programmed value down to zero at a prescaled rate and pulses `done` on expiry. Supports one-shot and periodic (auto-reload) modes, plus pause. Sits beside the free-running counters as the timeout/interval source for control FSMs.

---
 rtl/countdown_timer.sv | 71 +++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable prescaled down-counter with one-shot/periodic expiry pulse
module countdown_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] start_val;
    logic [PW-1:0]    pre;
    logic             tick;
    logic             rearm;

    // start value (a coincident load overrides the stored one), tick and periodic re-arm decisions
    always_comb begin
        start_val = load ? load_val : reload_reg;
        tick      = pre == PRE_MAX;
        rearm     = mode && reload_reg != '0;
    end

    assign busy = state != IDLE;

    // single-process FSM; the resume edge out of HOLD already counts so each paused cycle costs exactly one cycle
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            pre        <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) reload_reg <= load_val;
            if (start) begin
                count <= start_val;
                pre   <= '0;
                state <= start_val != '0 ? RUN : IDLE;
                done  <= start_val == '0;
            end else if (state == IDLE) begin
                if (load) count <= load_val;
            end else if (pause) begin
                state <= HOLD;
            end else begin
                state <= RUN;
                pre   <= tick ? '0 : pre + 1'b1;
                if (tick && count == WIDTH'(1)) begin
                    done  <= 1'b1;
                    count <= rearm ? reload_reg : '0;
                    state <= rearm ? RUN : IDLE;
                end else if (tick && count != '0) begin
                    count <= count - 1'b1;
                end
            end
        end
    end
endmodule
